// File: rtl/i2c_slave_xfer_pkg.sv
// Shared types for the I2C slave: FSM states, bus-event encoding, default address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_START = 2'd1,
    EV_STOP  = 2'd2
  } i2c_event_e;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h6A;

  function automatic i2c_event_e encode_event(input logic start_det, input logic stop_det);
    i2c_event_e ev;
    if (start_det) begin
      ev = EV_START;
    end else if (stop_det) begin
      ev = EV_STOP;
    end else begin
      ev = EV_NONE;
    end
    return ev;
  endfunction

endpackage

// File: rtl/i2c_slave_xfer_if.sv
// Pad-side and byte-stream signals of the I2C slave, with slave (DUT) and master (driver) views.
interface i2c_slave_xfer_if #(
  parameter int CNT_W = 6
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic             scl_oe;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       tx_data;
  logic             tx_load;
  logic             busy;
  logic             is_read;
  logic [CNT_W-1:0] byte_count;
  logic             overflow;
  logic             frame_done;

  modport slave (
    input  scl_in, sda_in, rx_ready, tx_data,
    output sda_oe, scl_oe, rx_data, rx_valid, tx_load, busy, is_read,
           byte_count, overflow, frame_done
  );

  modport master (
    output scl_in, sda_in, rx_ready, tx_data,
    input  sda_oe, scl_oe, rx_data, rx_valid, tx_load, busy, is_read,
           byte_count, overflow, frame_done
  );
endinterface

// File: rtl/i2c_slave_xfer_line_sync.sv
// SCL/SDA synchroniser with edge, START and STOP detection on the two oldest stages.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] r_scl;
  logic [SYNC_STAGES-1:0] r_sda;
  logic w_scl_now, w_scl_old, w_sda_now, w_sda_old;

  // Shift register synchroniser; idles high like a released bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl <= '1;
      r_sda <= '1;
    end else begin
      r_scl <= {r_scl[SYNC_STAGES-2:0], scl_in};
      r_sda <= {r_sda[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign w_scl_now = r_scl[SYNC_STAGES-2];
  assign w_scl_old = r_scl[SYNC_STAGES-1];
  assign w_sda_now = r_sda[SYNC_STAGES-2];
  assign w_sda_old = r_sda[SYNC_STAGES-1];

  assign scl_rise  = w_scl_now & ~w_scl_old;
  assign scl_fall  = ~w_scl_now & w_scl_old;
  assign sda_s     = w_sda_now;
  // SCL must be high on both stages so a data change racing an SCL edge is not a START/STOP.
  assign start_det = w_scl_now & w_scl_old & w_sda_old & ~w_sda_now;
  assign stop_det  = w_scl_now & w_scl_old & ~w_sda_old & w_sda_now;
endmodule

// File: rtl/i2c_slave_xfer.sv
// I2C slave with 7-bit addressing, read/write byte streams and repeated START.
// Optional SCL stretching while the receive sink is not ready: define I2C_CLK_STRETCH_EN.
module i2c_slave_xfer
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         MAX_BYTES   = 33,
  parameter int         SYNC_STAGES = 2,
  parameter int         CNT_W       = $clog2(MAX_BYTES + 1)
) (
  input logic             clk,
  input logic             reset,
  i2c_slave_xfer_if.slave bus
);
  logic w_scl_rise, w_scl_fall, w_sda, w_start, w_stop, w_rise, w_fall;
  i2c_event_e       w_evt;
  i2c_state_e       r_state;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift, r_tx_shift, r_rx_data;
  logic             r_sda_oe, r_rx_valid, r_tx_load, r_busy, r_is_read;
  logic             r_overflow, r_frame_done, r_nack;
  logic [CNT_W-1:0] r_byte_count;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk(clk), .reset(reset), .scl_in(bus.scl_in), .sda_in(bus.sda_in),
    .scl_rise(w_scl_rise), .scl_fall(w_scl_fall), .sda_s(w_sda),
    .start_det(w_start), .stop_det(w_stop)
  );

  assign w_evt = encode_event(w_start, w_stop);

`ifdef I2C_CLK_STRETCH_EN
  logic r_scl_oe;
  assign w_rise     = w_scl_rise & ~r_scl_oe;
  assign w_fall     = w_scl_fall & ~r_scl_oe;
  assign bus.scl_oe = r_scl_oe;

  // Hold SCL low after an ACKed byte until the sink can take the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_oe <= 1'b0;
    end else if (w_evt != EV_NONE) begin
      r_scl_oe <= 1'b0;
    end else if (r_scl_oe) begin
      r_scl_oe <= ~bus.rx_ready;
    end else if ((r_state == ST_RX_ACK) && w_scl_fall && !r_nack) begin
      r_scl_oe <= ~bus.rx_ready;
    end
  end
`else
  logic w_unused_rx_ready;
  assign w_unused_rx_ready = bus.rx_ready;
  assign w_rise     = w_scl_rise;
  assign w_fall     = w_scl_fall;
  assign bus.scl_oe = 1'b0;
`endif

  // Protocol FSM; START/STOP take priority over whatever state the frame is in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_tx_shift   <= 8'd0;
      r_rx_data    <= 8'd0;
      r_sda_oe     <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_tx_load    <= 1'b0;
      r_busy       <= 1'b0;
      r_is_read    <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_nack       <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_tx_load    <= 1'b0;
      r_frame_done <= 1'b0;
      case (w_evt)
        EV_START: begin
          r_state      <= ST_ADDR;
          r_bit_cnt    <= 4'd0;
          r_byte_count <= '0;
          r_overflow   <= 1'b0;
          r_sda_oe     <= 1'b0;
        end
        EV_STOP: begin
          r_state      <= ST_IDLE;
          r_sda_oe     <= 1'b0;
          r_frame_done <= r_busy;
          r_busy       <= 1'b0;
        end
        default: begin
          case (r_state)
            ST_ADDR: begin
              if (w_rise) begin
                r_shift   <= {r_shift[6:0], w_sda};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else if (w_fall && (r_bit_cnt == 4'd8)) begin
                r_bit_cnt <= 4'd0;
                if (r_shift[7:1] == SLAVE_ADDR) begin
                  r_state   <= ST_ADDR_ACK;
                  r_sda_oe  <= 1'b1;
                  r_is_read <= r_shift[0];
                  r_busy    <= 1'b1;
                end else begin
                  r_state   <= ST_WAIT_STOP;
                end
              end
            end
            ST_ADDR_ACK: begin
              if (w_fall) begin
                if (r_is_read) begin
                  r_state    <= ST_TX_BYTE;
                  r_tx_load  <= 1'b1;
                  r_sda_oe   <= ~bus.tx_data[7];
                  r_tx_shift <= {bus.tx_data[6:0], 1'b0};
                  r_bit_cnt  <= 4'd1;
                end else begin
                  r_state    <= ST_RX_BYTE;
                  r_sda_oe   <= 1'b0;
                  r_bit_cnt  <= 4'd0;
                end
              end
            end
            ST_RX_BYTE: begin
              if (w_rise) begin
                r_shift   <= {r_shift[6:0], w_sda};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else if (w_fall && (r_bit_cnt == 4'd8)) begin
                r_bit_cnt <= 4'd0;
                r_state   <= ST_RX_ACK;
                if (r_byte_count < CNT_W'(MAX_BYTES)) begin
                  r_rx_data    <= r_shift;
                  r_rx_valid   <= 1'b1;
                  r_byte_count <= r_byte_count + CNT_W'(1);
                  r_sda_oe     <= 1'b1;
                  r_nack       <= 1'b0;
                end else begin
                  r_overflow   <= 1'b1;
                  r_sda_oe     <= 1'b0;
                  r_nack       <= 1'b1;
                end
              end
            end
            ST_RX_ACK: begin
              if (w_fall) begin
                r_sda_oe <= 1'b0;
                r_state  <= r_nack ? ST_WAIT_STOP : ST_RX_BYTE;
              end
            end
            ST_TX_BYTE: begin
              if (w_fall) begin
                if (r_bit_cnt == 4'd8) begin
                  r_sda_oe <= 1'b0;
                  r_state  <= ST_TX_ACK;
                end else begin
                  r_sda_oe   <= ~r_tx_shift[7];
                  r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  r_bit_cnt  <= r_bit_cnt + 4'd1;
                end
              end
            end
            ST_TX_ACK: begin
              // r_nack holds the master's ACK bit, sampled on the rise.
              if (w_rise) begin
                r_nack <= w_sda;
              end else if (w_fall) begin
                if (!r_nack) begin
                  r_state    <= ST_TX_BYTE;
                  r_tx_load  <= 1'b1;
                  r_sda_oe   <= ~bus.tx_data[7];
                  r_tx_shift <= {bus.tx_data[6:0], 1'b0};
                  r_bit_cnt  <= 4'd1;
                  if (r_byte_count < CNT_W'(MAX_BYTES)) begin
                    r_byte_count <= r_byte_count + CNT_W'(1);
                  end
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
            default: begin
              r_sda_oe <= 1'b0;
            end
          endcase
        end
      endcase
    end
  end

  assign bus.sda_oe     = r_sda_oe;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.tx_load    = r_tx_load;
  assign bus.busy       = r_busy;
  assign bus.is_read    = r_is_read;
  assign bus.byte_count = r_byte_count;
  assign bus.overflow   = r_overflow;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_i2c_slave_xfer.sv
// Directed bench for i2c_slave_xfer: a bit-level I2C master plus a frame-level expectation model.
module tb_i2c_slave_xfer;
  localparam logic [6:0] SADDR = 7'h6A;
  localparam int MAXB = 3;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int Q    = 4;

  logic clk = 1'b0;
  logic reset;
  logic m_sda;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_tx_load = 0;
  int   n_frame_done = 0;
  bit   mdl_silent = 1'b1;
  logic [7:0] exp_rx[$];
  logic [7:0] wdata [0:5];
  logic [7:0] rdata [0:5];

  i2c_slave_xfer_if #(.CNT_W(CW)) bus ();

  i2c_slave_xfer #(
    .SLAVE_ADDR(SADDR), .MAX_BYTES(MAXB), .SYNC_STAGES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and slave on SDA.
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: receive stream, pulse counters and the quiet-bus rule every cycle.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) begin
        check("rx_valid_unexpected", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
      end else begin
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_rx.pop_front()});
      end
    end
    if (bus.tx_load === 1'b1) n_tx_load++;
    if (bus.frame_done === 1'b1) n_frame_done++;
    check("scl_oe_idle", {31'd0, bus.scl_oe}, 32'd0);
    if (mdl_silent) check("sda_quiet", {31'd0, bus.sda_oe}, 32'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic xfer_bit(input logic b, output logic line);
    m_sda = b;
    wait_q();
    bus.scl_in = 1'b1;
    wait_q();
    line = bus.sda_in;
    wait_q();
    bus.scl_in = 1'b0;
    wait_q();
  endtask

  task automatic xfer_byte(input logic [7:0] d, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], l);
    xfer_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] got);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, l);
      got[i] = l;
    end
    bus.tx_data = next_tx;
    xfer_bit(~mack, l);
  endtask

  task automatic do_start(input bit rstart);
    if (rstart) begin
      m_sda = 1'b1;
      wait_q();
      bus.scl_in = 1'b1;
      wait_q();
    end
    m_sda = 1'b0;
    wait_q();
    wait_q();
    bus.scl_in = 1'b0;
    wait_q();
    check("start_clears", {29'd0, bus.overflow, bus.byte_count}, 32'd0);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0;
    wait_q();
    bus.scl_in = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
    wait_q();
    check("busy_after_stop", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic write_frame(input logic [7:0] addr, input int n, input bit rstart);
    logic ack;
    bit   hit;
    int   acked;
    hit   = (addr[7:1] == SADDR) && !addr[0];
    acked = hit ? ((n < MAXB) ? n : MAXB) : 0;
    do_start(rstart);
    mdl_silent = !hit;
    for (int i = 0; i < n; i++) if (hit && i < MAXB) exp_rx.push_back(wdata[i]);
    xfer_byte(addr, ack);
    check("wr_addr_ack", {31'd0, ack}, {31'd0, hit});
    for (int i = 0; i < n; i++) begin
      xfer_byte(wdata[i], ack);
      check($sformatf("wr_data_ack%0d", i), {31'd0, ack}, {31'd0, (hit && i < MAXB)});
    end
    check("wr_byte_count", {30'd0, bus.byte_count}, acked);
    check("wr_overflow", {31'd0, bus.overflow}, {31'd0, (hit && n > MAXB)});
    check("wr_rx_drained", exp_rx.size(), 32'd0);
  endtask

  task automatic read_frame(input logic [7:0] addr, input int n, input bit rstart);
    logic       ack;
    logic [7:0] got;
    logic       l;
    int         ld0;
    bus.tx_data = rdata[0];
    do_start(rstart);
    mdl_silent = 1'b0;
    ld0 = n_tx_load;
    xfer_byte(addr, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    check("rd_is_read", {31'd0, bus.is_read}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, (i < n - 1) ? rdata[i + 1] : 8'h00, got);
      check($sformatf("rd_data%0d", i), {24'd0, got}, {24'd0, rdata[i]});
    end
    mdl_silent = 1'b1;
    xfer_bit(1'b1, l);
    xfer_bit(1'b1, l);
    check("rd_tx_load_count", n_tx_load - ld0, n);
    check("rd_byte_count", {30'd0, bus.byte_count}, n - 1);
    check("rd_busy_wait_stop", {31'd0, bus.busy}, 32'd1);
  endtask

  initial begin
    int   fd0;
    logic l;
    reset        = 1'b1;
    m_sda        = 1'b1;
    bus.scl_in   = 1'b1;
    bus.tx_data  = 8'h00;
    bus.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", {bus.sda_oe, bus.scl_oe, bus.rx_valid, bus.tx_load, bus.busy,
          bus.is_read, bus.overflow, bus.frame_done, bus.rx_data, bus.byte_count}, 32'd0);
    reset = 1'b0;
    wait_q();

    // Write of exactly MAX_BYTES bytes.
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
    fd0 = n_frame_done;
    write_frame(8'hD4, 3, 1'b0);
    check("wr_busy", {31'd0, bus.busy}, 32'd1);
    check("wr_last_rx_data", {24'd0, bus.rx_data}, 32'h33);
    check("wr_byte_count_lit", {30'd0, bus.byte_count}, 32'd3);
    stop_cond();
    check("wr_frame_done", n_frame_done - fd0, 32'd1);

    // Address mismatch: bus untouched, no frame.
    wdata[0] = 8'h05; wdata[1] = 8'h06;
    fd0 = n_frame_done;
    write_frame(8'hA0, 2, 1'b0);
    stop_cond();
    check("nm_frame_done", n_frame_done - fd0, 32'd0);

    // One byte past MAX_BYTES is NACKed.
    wdata[0] = 8'h01; wdata[1] = 8'h02; wdata[2] = 8'h03; wdata[3] = 8'h04;
    fd0 = n_frame_done;
    write_frame(8'hD4, 4, 1'b0);
    check("ov_overflow_lit", {31'd0, bus.overflow}, 32'd1);
    stop_cond();
    check("ov_frame_done", n_frame_done - fd0, 32'd1);

    // Master read: ACK, ACK, NACK.
    rdata[0] = 8'hA5; rdata[1] = 8'h3C; rdata[2] = 8'hF0;
    fd0 = n_frame_done;
    read_frame(8'hD5, 3, 1'b0);
    stop_cond();
    check("rd_frame_done", n_frame_done - fd0, 32'd1);

    // Write, repeated START, read: a single frame.
    wdata[0] = 8'h5A;
    rdata[0] = 8'hC3;
    fd0 = n_frame_done;
    write_frame(8'hD4, 1, 1'b0);
    read_frame(8'hD5, 1, 1'b1);
    stop_cond();
    check("sr_frame_done", n_frame_done - fd0, 32'd1);

    // Reset while driving the ACK of a received byte.
    fd0 = n_frame_done;
    do_start(1'b0);
    mdl_silent = 1'b0;
    exp_rx.push_back(8'h77);
    xfer_byte(8'hD4, l);
    check("rst_addr_ack", {31'd0, l}, 32'd1);
    for (int i = 7; i >= 0; i--) xfer_bit(((8'h77 >> i) & 8'h01) != 8'h00, l);
    check("rst_ack_driven", {31'd0, bus.sda_oe}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_sda_release", {31'd0, bus.sda_oe}, 32'd0);
    check("rst_outputs", {bus.sda_oe, bus.scl_oe, bus.rx_valid, bus.tx_load, bus.busy,
          bus.is_read, bus.overflow, bus.frame_done, bus.rx_data, bus.byte_count}, 32'd0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    wait_q();
    bus.scl_in = 1'b1;
    wait_q();
    wait_q();
    wdata[0] = 8'h11;
    write_frame(8'hD4, 1, 1'b0);
    stop_cond();
    check("rst_frame_done", n_frame_done - fd0, 32'd1);

    check("rx_queue_empty", exp_rx.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
